fb_byte_writer: RTL and testbench
=================================

// Module: fb_byte_writer
// PURPOSE
// - Upstream feeder of the dual-port framebuffer RAM's write port (port A: 12-bit address, 2-bit data).
// - Takes a byte stream from the command/UART path through a valid/ready handshake.
// - Unpacks each byte into four 2-bit pixel words and writes them to consecutive addresses.
// - Keeps the running write pointer; supports frame resync and wraps at frame end.
// PARAMETERS
// - ADDR_WIDTH   12    width of ram_a_address
// - DATA_WIDTH   2     RAM word width; 8/DATA_WIDTH = beats per byte (fixed 4 at default)
// - FRAME_WORDS  4096  words per frame; pointer wraps FRAME_WORDS-1 -> 0
// PORTS
// - clk               in   1   single clock; all state updates on rising edge
// - reset             in   1   asynchronous, active-high; clears all state immediately
// - byte_in           in   8   pixel byte; packed MSB-first, [7:6] goes to the lowest address
// - byte_valid        in   1   byte_in is valid
// - byte_ready        out  1   block can accept a byte this cycle
// - frame_start       in   1   1-cycle strobe; next byte starts at address 0
// - ram_a_address     out  12  RAM port A address
// - ram_a_data_in     out  2   RAM port A write data
// - ram_a_wr          out  1   RAM port A write enable
// - ram_a_clk_enable  out  1   RAM port A clock enable
// - frame_done        out  1   1-cycle pulse after the word at FRAME_WORDS-1 is written (macro only)
// BEHAVIOUR
// - Reset values: byte_ready=0, ram_a_address=0, ram_a_data_in=0, ram_a_wr=0, ram_a_clk_enable=0, frame_done=0.
// - Reset state: IDLE; word pointer 0; shift reg 0; pending-resync flag 0.
// - First edge after reset release: ram_a_clk_enable=1 (held thereafter); byte_ready=1.
// - All outputs are registered.
// - FSM IDLE:
//   - byte_ready=1, ram_a_wr=0, ram_a_address = pointer (next write address).
//   - Accept on edge E0 when byte_valid && byte_ready: latch byte, beat counter=0, go WRITE.
// - FSM WRITE:
//   - byte_ready=0, ram_a_wr=1, ram_a_data_in = shift[7:6], ram_a_address = pointer.
//   - Each edge: pointer+1 (with wrap), shift<<=2, beat+1.
//   - RAM captures writes at E1..E4 for beats 0..3.
//   - After E4: back to IDLE; ram_a_wr=0; byte_ready=1.
// - Throughput: 5 cycles per byte; a byte_valid held high is accepted every 5th cycle.
// - Wrap: pointer FRAME_WORDS-1 increments to 0, also mid-byte.
// - Pointer arithmetic is modulo FRAME_WORDS. Non-power-of-2 FRAME_WORDS compares against FRAME_WORDS-1.
// - frame_start in IDLE: pointer=0 on that edge.
// - frame_start together with an accepted byte_valid: pointer clears first; the byte writes to 0..3.
// - frame_start during WRITE: sets the pending flag; the current byte completes at unchanged addresses.
//   On return to IDLE, pointer=0 and the flag clears.
// - byte_valid while byte_ready=0: ignored. The source must hold byte_in/byte_valid until accepted.
// - Reset mid-byte: ram_a_wr drops immediately (async). The partial byte is discarded, not completed.
// CONFIGURATION
// - FB_WRITER_FRAME_DONE_EN defined:
//   - frame_done pulses high for exactly 1 cycle, on the cycle after the edge that writes address FRAME_WORDS-1.
//   - A pulse also occurs if frame_start coincides with that write.
// - FB_WRITER_FRAME_DONE_EN undefined:
//   - frame_done tied to 0; no wrap-detect logic is present.
//   - All other behaviour is identical.
// TESTING
// - Single byte: reset, byte_in=8'hB4 valid 1 cycle.
//   -> wr=1 for 4 cycles, data 2,3,1,0 at addresses 0,1,2,3.
//   -> byte_ready=0 for 4 cycles, then 1; address idles at 4.
// - Streaming: byte_valid held with bytes 8'hFF, 8'h00, 8'h1B.
//   -> 12 writes at addresses 0..11, data 3,3,3,3,0,0,0,0,0,1,2,3.
//   -> byte_ready high 1 of every 5 cycles.
// - Wrap: write 1023 bytes, then 8'hE4 -> addresses 4092..4095 get 3,2,1,0; idle address 0.
//   -> frame_done pulses once with the macro, stays 0 without it.
// - Resync mid-byte: pointer at 8, byte 8'h55, frame_start on beat 1.
//   -> writes 1,1,1,1 at 8..11, then idle address 0; next byte writes at 0..3.
// - Simultaneous: pointer at 8, frame_start + byte_valid (8'hAA) on the same edge -> writes 2,2,2,2 at 0..3.
// - Reset mid-byte: assert reset on beat 2 of the first byte.
//   -> ram_a_wr=0 and address=0 before the next edge; no further writes.
//   -> after release, byte_ready=1 and the next byte writes at 0..3.

Source files
------------

// File: rtl/fb_byte_writer.sv
// Byte-to-pixel unpacker that drives the framebuffer RAM write port, MSB pixel first.
// Define FB_WRITER_FRAME_DONE_EN to enable the end-of-frame pulse on frame_done.
module fb_byte_writer #(
    parameter int ADDR_WIDTH  = 12,
    parameter int DATA_WIDTH  = 2,
    parameter int FRAME_WORDS = 4096
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [7:0]            byte_in,
    input  logic                  byte_valid,
    output logic                  byte_ready,
    input  logic                  frame_start,
    output logic [ADDR_WIDTH-1:0] ram_a_address,
    output logic [DATA_WIDTH-1:0] ram_a_data_in,
    output logic                  ram_a_wr,
    output logic                  ram_a_clk_enable,
    output logic                  frame_done
);

    localparam int BEATS      = 8 / DATA_WIDTH;
    localparam int BEAT_WIDTH = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(FRAME_WORDS - 1);
    localparam logic [BEAT_WIDTH-1:0] LAST_BEAT = BEAT_WIDTH'(BEATS - 1);

    typedef enum logic {
        IDLE,
        WRITE
    } state_t;

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] ptr_q, ptr_d, ptr_inc;
    logic [7:0]            shift_q, shift_d, shift_next;
    logic [BEAT_WIDTH-1:0] beat_q, beat_d;
    logic                  pending_q, pending_d;
    logic                  ready_q, ready_d;
    logic                  wr_q, wr_d;
    logic                  clk_en_q;

    // Compare against the last word rather than relying on overflow, so odd frame sizes wrap correctly.
    assign ptr_inc    = (ptr_q == LAST_ADDR) ? '0 : ptr_q + ADDR_WIDTH'(1);
    assign shift_next = {shift_q[7-DATA_WIDTH:0], {DATA_WIDTH{1'b0}}};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            ptr_q     <= '0;
            shift_q   <= '0;
            beat_q    <= '0;
            pending_q <= 1'b0;
            ready_q   <= 1'b0;
            wr_q      <= 1'b0;
            clk_en_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            shift_q   <= shift_d;
            beat_q    <= beat_d;
            pending_q <= pending_d;
            ready_q   <= ready_d;
            wr_q      <= wr_d;
            clk_en_q  <= 1'b1;
        end
    end

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        shift_d   = shift_q;
        beat_d    = beat_q;
        pending_d = pending_q;
        ready_d   = ready_q;
        wr_d      = wr_q;
        case (state_q)
            IDLE: begin
                ready_d = 1'b1;
                wr_d    = 1'b0;
                if (frame_start) begin
                    ptr_d = '0;
                end
                if (byte_valid && ready_q) begin
                    shift_d = byte_in;
                    beat_d  = '0;
                    state_d = WRITE;
                    ready_d = 1'b0;
                    wr_d    = 1'b1;
                end
            end
            WRITE: begin
                ready_d = 1'b0;
                wr_d    = 1'b1;
                ptr_d   = ptr_inc;
                shift_d = shift_next;
                beat_d  = beat_q + BEAT_WIDTH'(1);
                if (frame_start) begin
                    pending_d = 1'b1;
                end
                // A resync requested during the byte only takes effect once its last pixel is written.
                if (beat_q == LAST_BEAT) begin
                    state_d = IDLE;
                    ready_d = 1'b1;
                    wr_d    = 1'b0;
                    if (pending_q || frame_start) begin
                        ptr_d     = '0;
                        pending_d = 1'b0;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign byte_ready       = ready_q;
    assign ram_a_address    = ptr_q;
    assign ram_a_data_in    = shift_q[7 -: DATA_WIDTH];
    assign ram_a_wr         = wr_q;
    assign ram_a_clk_enable = clk_en_q;

`ifdef FB_WRITER_FRAME_DONE_EN
    logic done_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            done_q <= 1'b0;
        end else begin
            done_q <= (state_q == WRITE) && (ptr_q == LAST_ADDR);
        end
    end

    assign frame_done = done_q;
`else
    assign frame_done = 1'b0;
`endif

endmodule

// File: tb/tb_fb_byte_writer.sv
// Self-checking bench for fb_byte_writer: directed scenarios plus random traffic,
// all compared against a transaction-level model of the expected RAM write stream.
module tb_fb_byte_writer;

    localparam int FW = 4096;

    logic        clk        = 1'b0;
    logic        reset      = 1'b0;
    logic [7:0]  byteIn     = 8'h00;
    logic        byteValid  = 1'b0;
    logic        frameStart = 1'b0;
    logic        byteReady;
    logic [11:0] ramAddr;
    logic [1:0]  ramData;
    logic        ramWr;
    logic        ramClkEn;
    logic        frameDone;

    int total = 0;
    int bad   = 0;

    // Model state: pointer, writes still to be presented, pending resync, armed after reset.
    int mPtr;
    int mRemaining;
    bit mPending;
    bit mArmed;
    bit mDoneExp;
    bit mAccepted;
    int expAddr[$];
    int expData[$];

    // Log of writes the DUT actually presented, for direct checks against spec vectors.
    int logAddr[$];
    int logData[$];
    int doneSeen;

    always #5 clk = ~clk;

    fb_byte_writer dut (
        .clk              (clk),
        .reset            (reset),
        .byte_in          (byteIn),
        .byte_valid       (byteValid),
        .byte_ready       (byteReady),
        .frame_start      (frameStart),
        .ram_a_address    (ramAddr),
        .ram_a_data_in    (ramData),
        .ram_a_wr         (ramWr),
        .ram_a_clk_enable (ramClkEn),
        .frame_done       (frameDone)
    );

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic modelReset();
        mPtr       = 0;
        mRemaining = 0;
        mPending   = 1'b0;
        mArmed     = 1'b0;
        mDoneExp   = 1'b0;
        mAccepted  = 1'b0;
        expAddr.delete();
        expData.delete();
    endtask

    // Advance the model across one rising edge given the inputs presented to that edge.
    task automatic modelEdge(input logic v, input logic [7:0] b, input logic fs);
        mAccepted = 1'b0;
        mDoneExp  = 1'b0;
        if (mRemaining > 0) begin
            if (expAddr[0] == FW - 1) mDoneExp = 1'b1;
            void'(expAddr.pop_front());
            void'(expData.pop_front());
            mRemaining--;
            if (fs) mPending = 1'b1;
            if (mRemaining == 0 && mPending) begin
                mPtr     = 0;
                mPending = 1'b0;
            end
        end else if (mArmed) begin
            if (fs) mPtr = 0;
            if (v) begin
                for (int k = 0; k < 4; k++) begin
                    expAddr.push_back((mPtr + k) % FW);
                    expData.push_back((int'(b) >> (6 - 2 * k)) & 3);
                end
                mPtr       = (mPtr + 4) % FW;
                mRemaining = 4;
                mAccepted  = 1'b1;
            end
        end
        mArmed = 1'b1;
    endtask

    task automatic compareOutputs();
        if (frameDone === 1'b1) doneSeen++;
        checkOutput("wr", ramWr, mRemaining > 0);
        checkOutput("ready", byteReady, mArmed && mRemaining == 0);
        checkOutput("clkEn", ramClkEn, mArmed);
`ifdef FB_WRITER_FRAME_DONE_EN
        checkOutput("frameDone", frameDone, mDoneExp);
`else
        checkOutput("frameDone", frameDone, 1'b0);
`endif
        if (mRemaining > 0) begin
            checkOutput("wrAddr", ramAddr, expAddr[0]);
            checkOutput("wrData", ramData, expData[0]);
        end else begin
            checkOutput("idleAddr", ramAddr, mPtr);
        end
        if (ramWr === 1'b1) begin
            logAddr.push_back(int'(ramAddr));
            logData.push_back(int'(ramData));
        end
    endtask

    // One clock: drive inputs, step the model, then sample outputs 1ns after the edge.
    task automatic applyStimulus(input logic v, input logic [7:0] b, input logic fs);
        byteValid  = v;
        byteIn     = b;
        frameStart = fs;
        modelEdge(v, b, fs);
        @(posedge clk);
        #1;
        byteValid  = 1'b0;
        frameStart = 1'b0;
        compareOutputs();
    endtask

    task automatic idleCycles(input int n);
        for (int i = 0; i < n; i++) applyStimulus(1'b0, 8'h00, 1'b0);
    endtask

    // Hold the byte valid until the model says it was taken.
    task automatic sendByte(input logic [7:0] b);
        for (int n = 0; n < 10; n++) begin
            applyStimulus(1'b1, b, 1'b0);
            if (mAccepted) break;
        end
    endtask

    task automatic doReset();
        reset      = 1'b1;
        byteValid  = 1'b0;
        frameStart = 1'b0;
        modelReset();
        #1;
        checkOutput("rstWr", ramWr, 1'b0);
        checkOutput("rstAddr", ramAddr, 0);
        checkOutput("rstData", ramData, 0);
        checkOutput("rstReady", byteReady, 1'b0);
        checkOutput("rstClkEn", ramClkEn, 1'b0);
        checkOutput("rstDone", frameDone, 1'b0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        logAddr.delete();
        logData.delete();
        doneSeen = 0;
    endtask

    task automatic checkLog(input string tag, input int first, input int baseAddr, input int data[4]);
        for (int k = 0; k < 4; k++) begin
            checkOutput({tag, "Addr"}, logAddr[first + k], baseAddr + k);
            checkOutput({tag, "Data"}, logData[first + k], data[k]);
        end
    endtask

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached, got timeout, expected finish");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int d[4];
        int stream[12];
        logic [7:0] cur;
        bit have;

        #1;
        // Single byte B4 after reset.
        doReset();
        idleCycles(1);
        sendByte(8'hB4);
        idleCycles(5);
        d = '{2, 3, 1, 0};
        checkOutput("t1Count", logAddr.size(), 4);
        checkLog("t1", 0, 0, d);
        checkOutput("t1IdleAddr", ramAddr, 4);

        // Streaming three bytes back to back.
        doReset();
        idleCycles(1);
        sendByte(8'hFF);
        sendByte(8'h00);
        sendByte(8'h1B);
        idleCycles(5);
        stream = '{3, 3, 3, 3, 0, 0, 0, 0, 0, 1, 2, 3};
        checkOutput("t2Count", logAddr.size(), 12);
        for (int k = 0; k < 12; k++) begin
            checkOutput("t2Addr", logAddr[k], k);
            checkOutput("t2Data", logData[k], stream[k]);
        end

        // Resync mid-byte with pointer at 8.
        doReset();
        idleCycles(1);
        sendByte(8'($urandom));
        sendByte(8'($urandom));
        idleCycles(4);
        logAddr.delete();
        logData.delete();
        sendByte(8'h55);
        applyStimulus(1'b0, 8'h00, 1'b0);
        applyStimulus(1'b0, 8'h00, 1'b1);
        idleCycles(3);
        checkOutput("t3IdleAddr", ramAddr, 0);
        sendByte(8'h3C);
        idleCycles(4);
        d = '{1, 1, 1, 1};
        checkLog("t3a", 0, 8, d);
        d = '{0, 3, 3, 0};
        checkLog("t3b", 4, 0, d);

        // Frame start together with an accepted byte, pointer at 8.
        doReset();
        idleCycles(1);
        sendByte(8'($urandom));
        sendByte(8'($urandom));
        idleCycles(4);
        logAddr.delete();
        logData.delete();
        applyStimulus(1'b1, 8'hAA, 1'b1);
        idleCycles(4);
        d = '{2, 2, 2, 2};
        checkOutput("t4Count", logAddr.size(), 4);
        checkLog("t4", 0, 0, d);

        // Wrap at frame end.
        doReset();
        idleCycles(1);
        for (int i = 0; i < 1023; i++) sendByte(8'($urandom));
        sendByte(8'hE4);
        idleCycles(5);
        d = '{3, 2, 1, 0};
        checkOutput("t5Count", logAddr.size(), FW);
        checkLog("t5", FW - 4, FW - 4, d);
        checkOutput("t5IdleAddr", ramAddr, 0);
`ifdef FB_WRITER_FRAME_DONE_EN
        checkOutput("t5DonePulses", doneSeen, 1);
`else
        checkOutput("t5DonePulses", doneSeen, 0);
`endif

        // Reset asserted on beat 2 of the first byte.
        doReset();
        idleCycles(1);
        sendByte(8'($urandom));
        idleCycles(2);
        checkOutput("t6Beat2Wr", ramWr, 1'b1);
        doReset();
        idleCycles(1);
        checkOutput("t6NoWrites", logAddr.size(), 0);
        sendByte(8'h3C);
        idleCycles(4);
        d = '{0, 3, 3, 0};
        checkLog("t6", 0, 0, d);

        // Random traffic with occasional resync strobes.
        doReset();
        idleCycles(1);
        have = 1'b0;
        cur  = 8'h00;
        for (int i = 0; i < 800; i++) begin
            if (!have && ($urandom % 3 != 0)) begin
                have = 1'b1;
                cur  = 8'($urandom);
            end
            applyStimulus(have, cur, ($urandom % 25) == 0);
            if (mAccepted) have = 1'b0;
        end
        idleCycles(5);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
